hazard_stall_unit: RTL and testbench
====================================

// Module: hazard_stall_unit
// PURPOSE
// Producer-side companion of the EX/MEM forwarding mux selects: detects the RAW hazards forwarding cannot cover.
// Sits beside ID; drives pipeline freeze (STALL) and EX-bubble insertion (BUBBLE).
// Covers load-use, multi-cycle RV32M mul/div dependencies and data-memory wait states; also launches the mul/div unit.
// PARAMETERS
// MD_TIMEOUT  40  max cycles MD_BUSY may wait for MD_DONE before forced abort
// CNT_W       16  width of the saturating stall-cycle performance counter
// PORTS
// CLK       in   1      rising-edge clock
// RESET     in   1      synchronous, active-low reset
// ID_VALID  in   1      valid instruction in ID
// ID_ADDR1  in   5      rs1 of ID instruction
// ID_ADDR2  in   5      rs2 of ID instruction
// ID_USE1   in   1      ID instruction reads rs1
// ID_USE2   in   1      ID instruction reads rs2
// ID_WADDR  in   5      rd of ID instruction
// ID_CLASS  in   2      00 single-cycle ALU/branch, 01 load, 10 mul/div, 11 treated as 00
// FLUSH     in   1      kill ID instruction (taken branch/jump resolved in EX)
// MEM_BUSY  in   1      data memory has not completed; whole pipeline must freeze
// MD_DONE   in   1      mul/div unit result valid this cycle (single-cycle pulse)
// STALL     out  1      hold PC and IF/ID register
// BUBBLE    out  1      write NOP into ID/EX register
// MD_START  out  1      one-cycle launch pulse to mul/div unit
// MD_ERR    out  1      one-cycle pulse: mul/div timeout abort
// STALL_CNT out  CNT_W  cycles with STALL=1, saturating at all-ones
// BEHAVIOUR
// - ISSUE = ID_VALID & ~STALL & ~FLUSH. Register x0 never creates a hazard, as source or destination.
// - STALL and BUBBLE are combinational from registered state + ID inputs; all other outputs are registered.
// - Reset (RESET=0 at a clock edge): state RUN; LD_PEND=0, LD_RD=0, MD_RD=0, MD_CNT=0; MD_START=0, MD_ERR=0, STALL_CNT=0.
// - Reset mid-operation discards any in-flight mul/div tracking; no MD_START reissue.
// - Load tracking: ISSUE of class 01 with rd!=0 sets LD_PEND=1 and LD_RD=rd.
// - LD_PEND clears on the next cycle with MEM_BUSY=0 (load has left EX).
// - Load-use hit: LD_PEND & ID_VALID & ((USE1 & ADDR1==LD_RD) | (USE2 & ADDR2==LD_RD)).
// - FSM states: RUN, MD_BUSY.
// - RUN -> MD_BUSY: ISSUE of class 10. MD_START=1 the next cycle; MD_RD=rd (0 allowed); MD_CNT=0.
// - In MD_BUSY, MD_CNT increments each cycle.
// - MD_BUSY -> RUN on MD_DONE; stall release is visible the cycle after MD_DONE.
// - MD_BUSY -> RUN when MD_CNT==MD_TIMEOUT-1 without MD_DONE; MD_ERR pulses one cycle.
// - MD hit (MD_BUSY & ID_VALID): source matches MD_RD (with USE), ID_WADDR==MD_RD (WAW, rd!=0), or ID_CLASS==10.
// - Priority 1: MEM_BUSY -> STALL=1, BUBBLE=0 (full freeze). LD_PEND and MD_CNT still advance per the rules above.
// - Priority 2: MD hit -> STALL=1, BUBBLE=1.
// - Priority 3: load-use hit -> STALL=1, BUBBLE=1, exactly one cycle per load.
// - Otherwise STALL=0, BUBBLE=0.
// - FLUSH=1: STALL=0, BUBBLE=0 unless MEM_BUSY; the ID instruction never issues.
// - FLUSH never cancels an in-flight mul/div or a pending load (both are older).
// - MD_DONE in RUN is ignored. MD_DONE and timeout in the same cycle: MD_DONE wins, no MD_ERR.
// - STALL_CNT increments on every cycle with STALL=1 and holds at 2^CNT_W-1.
// TESTING
// - lw x5 issues, next cycle add x6,x5,x1 in ID -> STALL=BUBBLE=1 for 1 cycle, then issues; STALL_CNT=1.
// - lw x0 then add x6,x0,x0 -> no stall. lw x5 then add with USE1=0, ADDR1=5 -> no stall.
// - mul x7 issues -> MD_START pulse next cycle; sub x8,x7,x2 stalls until MD_DONE at cycle 10.
// - Same case: ISSUE at 11, STALL_CNT=10.
// - mul x7, MD_DONE never arrives -> MD_ERR pulse after 40 busy cycles; state RUN; dependent instruction issues next cycle.
// - MEM_BUSY=1 for 3 cycles together with a load-use hit -> STALL=1, BUBBLE=0 for 3 cycles.
// - After MEM_BUSY drops: LD_PEND cleared, no extra bubble.
// - RESET=0 during MD_BUSY with STALL=1 -> next cycle all outputs 0, STALL_CNT=0, state RUN.

Source files
------------

// File: rtl/hazard_stall_unit.sv
// Hazard detection beside ID: load-use and mul/div RAW/WAW stalls, data-memory freeze,
// mul/div launch with timeout abort, and a saturating stall-cycle counter.
module hazard_stall_unit #(
    parameter int MD_TIMEOUT = 40,
    parameter int CNT_W      = 16
) (
    input  logic             clk_i,
    input  logic             reset_ni,
    input  logic             id_valid_i,
    input  logic [4:0]       id_addr1_i,
    input  logic [4:0]       id_addr2_i,
    input  logic             id_use1_i,
    input  logic             id_use2_i,
    input  logic [4:0]       id_waddr_i,
    input  logic [1:0]       id_class_i,
    input  logic             flush_i,
    input  logic             mem_busy_i,
    input  logic             md_done_i,
    output logic             stall_o,
    output logic             bubble_o,
    output logic             md_start_o,
    output logic             md_err_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic             state_o
);

    localparam int                  MD_CNT_W = $clog2(MD_TIMEOUT + 1);
    localparam logic [MD_CNT_W-1:0] MD_LAST  = MD_CNT_W'(MD_TIMEOUT - 1);
    localparam logic [1:0]          CLS_LD   = 2'b01;
    localparam logic [1:0]          CLS_MD   = 2'b10;

    typedef enum logic {
        RUN     = 1'b0,
        MD_BUSY = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic                ld_pend_q, ld_pend_d;
    logic [4:0]          ld_rd_q, ld_rd_d;
    logic [4:0]          md_rd_q, md_rd_d;
    logic [MD_CNT_W-1:0] md_cnt_q, md_cnt_d;
    logic                md_start_q, md_start_d;
    logic                md_err_q, md_err_d;
    logic [CNT_W-1:0]    stall_cnt_q, stall_cnt_d;

    logic ld_hit, md_hit, md_rd_nz, issue;

    // Hazard detection and stall/bubble priority; x0 never matches because
    // LD_RD is only loaded with a nonzero rd and MD matches require md_rd_nz.
    always_comb begin
        ld_hit   = ld_pend_q & id_valid_i &
                   ((id_use1_i & (id_addr1_i == ld_rd_q)) |
                    (id_use2_i & (id_addr2_i == ld_rd_q)));
        md_rd_nz = (md_rd_q != 5'd0);
        md_hit   = (state_q == MD_BUSY) & id_valid_i &
                   ((md_rd_nz & ((id_use1_i & (id_addr1_i == md_rd_q)) |
                                 (id_use2_i & (id_addr2_i == md_rd_q)) |
                                 (id_waddr_i == md_rd_q))) |
                    (id_class_i == CLS_MD));
        stall_o  = 1'b0;
        bubble_o = 1'b0;
        if (mem_busy_i) begin
            stall_o = 1'b1;
        end else if (flush_i) begin
            stall_o = 1'b0;
        end else if (md_hit || ld_hit) begin
            stall_o  = 1'b1;
            bubble_o = 1'b1;
        end
        issue = id_valid_i & ~stall_o & ~flush_i;
    end

    // Mul/div protocol: md_start_o pulses once per launch; md_done_i is accepted only in MD_BUSY.
    always_comb begin
        state_d     = state_q;
        ld_pend_d   = ld_pend_q;
        ld_rd_d     = ld_rd_q;
        md_rd_d     = md_rd_q;
        md_cnt_d    = md_cnt_q;
        md_start_d  = 1'b0;
        md_err_d    = 1'b0;
        stall_cnt_d = stall_cnt_q;

        if (issue && (id_class_i == CLS_LD) && (id_waddr_i != 5'd0)) begin
            ld_pend_d = 1'b1;
            ld_rd_d   = id_waddr_i;
        end else if (!mem_busy_i) begin
            ld_pend_d = 1'b0;
        end

        case (state_q)
            RUN: begin
                if (issue && (id_class_i == CLS_MD)) begin
                    state_d    = MD_BUSY;
                    md_start_d = 1'b1;
                    md_rd_d    = id_waddr_i;
                    md_cnt_d   = '0;
                end
            end
            MD_BUSY: begin
                if (md_done_i) begin
                    state_d = RUN;
                end else if (md_cnt_q == MD_LAST) begin
                    state_d  = RUN;
                    md_err_d = 1'b1;
                end else begin
                    md_cnt_d = md_cnt_q + MD_CNT_W'(1);
                end
            end
            default: state_d = RUN;
        endcase

        if (stall_o && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            state_q     <= RUN;
            ld_pend_q   <= 1'b0;
            ld_rd_q     <= 5'd0;
            md_rd_q     <= 5'd0;
            md_cnt_q    <= '0;
            md_start_q  <= 1'b0;
            md_err_q    <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            ld_pend_q   <= ld_pend_d;
            ld_rd_q     <= ld_rd_d;
            md_rd_q     <= md_rd_d;
            md_cnt_q    <= md_cnt_d;
            md_start_q  <= md_start_d;
            md_err_q    <= md_err_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign md_start_o  = md_start_q;
    assign md_err_o    = md_err_q;
    assign stall_cnt_o = stall_cnt_q;
    assign state_o     = state_q;

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Bench for hazard_stall_unit: per-cycle vectors with expected outputs queued at drive
// time and compared mid-cycle, plus hand-built mul/div, reset and saturation sequences.
module tb_hazard_stall_unit;

    localparam logic [1:0] C_ALU = 2'b00;
    localparam logic [1:0] C_LD  = 2'b01;
    localparam logic [1:0] C_MD  = 2'b10;
    localparam int         W     = 20;

    logic        clk = 1'b0;
    logic        reset_ni = 1'b0;
    logic        id_valid = 1'b0;
    logic [4:0]  id_addr1 = '0, id_addr2 = '0, id_waddr = '0;
    logic        id_use1 = 1'b0, id_use2 = 1'b0;
    logic [1:0]  id_class = '0;
    logic        flush = 1'b0, mem_busy = 1'b0, md_done = 1'b0;
    logic        stall, bubble, md_start, md_err, state;
    logic [15:0] stall_cnt;

    typedef struct {
        logic       rst_n;
        logic       valid;
        logic [1:0] cls;
        logic [4:0] wa;
        logic       u1;
        logic [4:0] a1;
        logic       u2;
        logic [4:0] a2;
        logic       flush;
        logic       mb;
        logic       done;
        logic       e_stall;
        logic       e_bubble;
        logic       e_start;
        logic       e_err;
    } vec_t;

    logic [W-1:0] exp_q[$];
    vec_t         tbl[$];
    logic [15:0]  cnt_model = '0;
    int           n_chk = 0;
    int           n_err = 0;

    hazard_stall_unit #(.MD_TIMEOUT(40), .CNT_W(16)) dut (
        .clk_i      (clk),
        .reset_ni   (reset_ni),
        .id_valid_i (id_valid),
        .id_addr1_i (id_addr1),
        .id_addr2_i (id_addr2),
        .id_use1_i  (id_use1),
        .id_use2_i  (id_use2),
        .id_waddr_i (id_waddr),
        .id_class_i (id_class),
        .flush_i    (flush),
        .mem_busy_i (mem_busy),
        .md_done_i  (md_done),
        .stall_o    (stall),
        .bubble_o   (bubble),
        .md_start_o (md_start),
        .md_err_o   (md_err),
        .stall_cnt_o(stall_cnt),
        .state_o    (state)
    );

    always #5 clk = ~clk;

    function automatic vec_t op(input logic [1:0] cls, input logic [4:0] wa,
                                input logic u1, input logic [4:0] a1,
                                input logic u2, input logic [4:0] a2);
        vec_t s;
        s.rst_n = 1'b1; s.valid = 1'b1; s.cls = cls; s.wa = wa;
        s.u1 = u1; s.a1 = a1; s.u2 = u2; s.a2 = a2;
        s.flush = 1'b0; s.mb = 1'b0; s.done = 1'b0;
        s.e_stall = 1'b0; s.e_bubble = 1'b0; s.e_start = 1'b0; s.e_err = 1'b0;
        return s;
    endfunction

    function automatic vec_t idle();
        vec_t s;
        s = op(C_ALU, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0);
        s.valid = 1'b0;
        return s;
    endfunction

    function automatic vec_t ctl(input vec_t s_in, input logic fl, input logic mb, input logic dn);
        vec_t s;
        s = s_in; s.flush = fl; s.mb = mb; s.done = dn;
        return s;
    endfunction

    function automatic vec_t ex(input vec_t s_in, input logic st, input logic bu,
                                input logic sa, input logic er);
        vec_t s;
        s = s_in; s.e_stall = st; s.e_bubble = bu; s.e_start = sa; s.e_err = er;
        return s;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, got, want);
        end
    endtask

    // One clock cycle: drive after the edge, queue the expectation, compare mid-cycle.
    task automatic run(input vec_t s, input string name);
        logic [W-1:0] e, g;
        @(posedge clk);
        #1;
        reset_ni = s.rst_n; id_valid = s.valid; id_class = s.cls; id_waddr = s.wa;
        id_use1 = s.u1; id_addr1 = s.a1; id_use2 = s.u2; id_addr2 = s.a2;
        flush = s.flush; mem_busy = s.mb; md_done = s.done;
        exp_q.push_back({s.e_stall, s.e_bubble, s.e_start, s.e_err, cnt_model});
        #3;
        g = {stall, bubble, md_start, md_err, stall_cnt};
        e = exp_q.pop_front();
        n_chk++;
        if (g !== e) begin
            n_err++;
            $display("FAIL %s: got stall=%0b bubble=%0b start=%0b err=%0b cnt=%0d, expected stall=%0b bubble=%0b start=%0b err=%0b cnt=%0d",
                     name, g[19], g[18], g[17], g[16], g[15:0], e[19], e[18], e[17], e[16], e[15:0]);
        end
        if (!s.rst_n) cnt_model = '0;
        else if (s.e_stall && cnt_model != 16'hFFFF) cnt_model = cnt_model + 16'd1;
    endtask

    initial begin
        vec_t sub;
        int   n;
        sub = op(C_ALU, 5'd8, 1'b1, 5'd7, 1'b1, 5'd2);

        // load-use, x0, unused source, flush and mem-busy vectors
        tbl.push_back(ex(idle(), 0, 0, 0, 0));
        tbl.push_back(ex(op(C_LD, 5'd5, 1, 5'd1, 0, 5'd0), 0, 0, 0, 0));
        tbl.push_back(ex(op(C_ALU, 5'd6, 1, 5'd5, 1, 5'd1), 1, 1, 0, 0));
        tbl.push_back(ex(op(C_ALU, 5'd6, 1, 5'd5, 1, 5'd1), 0, 0, 0, 0));
        tbl.push_back(ex(idle(), 0, 0, 0, 0));
        tbl.push_back(ex(op(C_LD, 5'd0, 1, 5'd2, 0, 5'd0), 0, 0, 0, 0));
        tbl.push_back(ex(op(C_ALU, 5'd6, 1, 5'd0, 1, 5'd0), 0, 0, 0, 0));
        tbl.push_back(ex(op(C_LD, 5'd5, 1, 5'd1, 0, 5'd0), 0, 0, 0, 0));
        tbl.push_back(ex(op(C_ALU, 5'd6, 0, 5'd5, 1, 5'd3), 0, 0, 0, 0));
        tbl.push_back(ex(op(C_LD, 5'd9, 1, 5'd1, 0, 5'd0), 0, 0, 0, 0));
        tbl.push_back(ex(op(C_ALU, 5'd10, 1, 5'd1, 1, 5'd9), 1, 1, 0, 0));
        tbl.push_back(ex(op(C_ALU, 5'd10, 1, 5'd1, 1, 5'd9), 0, 0, 0, 0));
        tbl.push_back(ex(op(C_LD, 5'd4, 1, 5'd1, 0, 5'd0), 0, 0, 0, 0));
        tbl.push_back(ex(ctl(op(C_ALU, 5'd11, 1, 5'd4, 0, 5'd0), 1, 0, 0), 0, 0, 0, 0));
        tbl.push_back(ex(op(C_ALU, 5'd11, 1, 5'd4, 0, 5'd0), 0, 0, 0, 0));
        tbl.push_back(ex(ctl(op(C_LD, 5'd3, 1, 5'd1, 0, 5'd0), 1, 0, 0), 0, 0, 0, 0));
        tbl.push_back(ex(op(C_ALU, 5'd12, 1, 5'd3, 0, 5'd0), 0, 0, 0, 0));
        tbl.push_back(ex(op(2'b11, 5'd5, 0, 5'd0, 0, 5'd0), 0, 0, 0, 0));
        tbl.push_back(ex(op(C_ALU, 5'd6, 1, 5'd5, 0, 5'd0), 0, 0, 0, 0));
        tbl.push_back(ex(op(C_LD, 5'd5, 1, 5'd1, 0, 5'd0), 0, 0, 0, 0));
        for (int i = 0; i < 3; i++)
            tbl.push_back(ex(ctl(op(C_ALU, 5'd6, 1, 5'd5, 1, 5'd1), 0, 1, 0), 1, 0, 0, 0));
        tbl.push_back(ex(op(C_ALU, 5'd6, 1, 5'd5, 1, 5'd1), 1, 1, 0, 0));
        tbl.push_back(ex(op(C_ALU, 5'd6, 1, 5'd5, 1, 5'd1), 0, 0, 0, 0));
        tbl.push_back(ex(ctl(op(C_ALU, 5'd1, 0, 5'd0, 0, 5'd0), 1, 1, 0), 1, 0, 0, 0));
        tbl.push_back(ex(ctl(idle(), 0, 0, 1), 0, 0, 0, 0));

        // clock/reset
        repeat (2) @(posedge clk);
        #1 reset_ni = 1'b1;
        #3;
        chk("reset_state", 32'(state), 32'd0);
        chk("reset_cnt", 32'(stall_cnt), 32'd0);
        chk("reset_start_err", 32'({md_start, md_err}), 32'd0);

        for (int i = 0; i < tbl.size(); i++) run(tbl[i], $sformatf("vec%0d", i));

        // mul x7 completing after 10 stall cycles, counted from a fresh reset
        run(ex(ctl(idle(), 0, 0, 0), 0, 0, 0, 0), "pre_rst");
        begin
            vec_t r;
            r = idle(); r.rst_n = 1'b0;
            run(r, "rst_pulse");
        end
        run(ex(op(C_MD, 5'd7, 1, 5'd1, 1, 5'd2), 0, 0, 0, 0), "mul_issue");
        for (int k = 1; k <= 10; k++)
            run(ex(ctl(sub, 0, 0, k == 10), 1, 1, k == 1, 0), $sformatf("md_wait%0d", k));
        run(ex(sub, 0, 0, 0, 0), "md_release");
        chk("stall_cnt_10", 32'(stall_cnt), 32'd10);

        // timeout, with independent/WAW/class-10/mem-busy traffic while busy
        run(ex(op(C_MD, 5'd7, 1, 5'd1, 1, 5'd2), 0, 0, 0, 0), "mul2_issue");
        for (int k = 1; k <= 40; k++) begin
            if (k <= 2)      run(ex(op(C_ALU, 5'd9, 1, 5'd1, 1, 5'd2), 0, 0, k == 1, 0), "md_indep");
            else if (k == 3) run(ex(op(C_ALU, 5'd7, 1, 5'd1, 1, 5'd2), 1, 1, 0, 0), "md_waw");
            else if (k == 4) run(ex(op(C_MD, 5'd13, 1, 5'd1, 1, 5'd2), 1, 1, 0, 0), "md_class10");
            else if (k == 5) run(ex(op(C_ALU, 5'd9, 1, 5'd1, 0, 5'd7), 0, 0, 0, 0), "md_nouse");
            else if (k <= 8) run(ex(ctl(sub, 0, 1, 0), 1, 0, 0, 0), "md_membusy");
            else             run(ex(sub, 1, 1, 0, 0), "md_to_wait");
            if (k == 20) chk("state_busy", 32'(state), 32'd1);
        end
        run(ex(sub, 0, 0, 0, 1), "md_timeout");
        chk("state_run_after_to", 32'(state), 32'd0);
        run(ex(idle(), 0, 0, 0, 0), "md_err_clear");

        // MD_DONE on the timeout cycle wins
        run(ex(op(C_MD, 5'd7, 1, 5'd1, 1, 5'd2), 0, 0, 0, 0), "mul3_issue");
        for (int k = 1; k <= 40; k++)
            run(ex(ctl(sub, 0, 0, k == 40), 1, 1, k == 1, 0), "md_done_last");
        run(ex(sub, 0, 0, 0, 0), "md_done_no_err");

        // mul x0: no register hazard
        run(ex(op(C_MD, 5'd0, 1, 5'd1, 1, 5'd2), 0, 0, 0, 0), "mulx0_issue");
        run(ex(op(C_ALU, 5'd0, 1, 5'd0, 1, 5'd0), 0, 0, 1, 0), "mulx0_use");
        run(ex(ctl(op(C_ALU, 5'd5, 1, 5'd3, 0, 5'd0), 0, 0, 1), 0, 0, 0, 0), "mulx0_done");

        // reset while stalled on mul/div
        run(ex(op(C_MD, 5'd7, 1, 5'd1, 1, 5'd2), 0, 0, 0, 0), "mul4_issue");
        for (int k = 1; k <= 3; k++)
            run(ex(sub, 1, 1, k == 1, 0), "rst_md_wait");
        begin
            vec_t r;
            r = ex(sub, 1, 1, 0, 0); r.rst_n = 1'b0;
            run(r, "rst_md_cycle");
        end
        run(ex(sub, 0, 0, 0, 0), "rst_md_after");
        chk("rst_md_state", 32'(state), 32'd0);
        for (int k = 0; k < 3; k++)
            run(ex(idle(), 0, 0, 0, 0), "rst_no_restart");

        // counter saturation under a long memory freeze
        n = 65535 - int'(cnt_model) + 3;
        @(posedge clk);
        #1;
        id_valid = 1'b0; flush = 1'b0; md_done = 1'b0; mem_busy = 1'b1;
        repeat (n) @(posedge clk);
        #3;
        chk("cnt_saturated", 32'(stall_cnt), 32'hFFFF);
        chk("freeze_stall", 32'({stall, bubble}), 32'd2);
        cnt_model = 16'hFFFF;
        run(ex(idle(), 0, 0, 0, 0), "cnt_hold1");
        run(ex(idle(), 0, 0, 0, 0), "cnt_hold2");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
